// File: rtl/jpeg_bit_window.sv
// ---------------------------------------------------------------------------
// jpeg_bit_window
//
// MSB-aligned bit window sitting between the JPEG header parser and the
// Huffman decoder. Scan bytes are appended behind the valid bits, byte
// stuffing (FF 00) is removed, fill bytes (FF FF) are skipped, and a real
// marker (FF xx, xx not 00/FF) is reported and halts intake until flush.
//
// Optional feature macro: JPEG_BITWIN_STUFF_CNT_EN
//   defined   -> stuff_cnt counts removed stuff 0x00 bytes (saturating)
//   undefined -> stuff_cnt is tied to 0, no counter register
//
// Ports
//   clk, rst_n     clock, asynchronous active-low reset
//   byte_in        scan byte, qualified by byte_valid / byte_ready
//   peek_bits      next PEEK_W unconsumed bits, MSB first, zero past bits_avail
//   bits_avail     number of valid bits in the window
//   consume_valid  drop consume_len bits (1..PEEK_W, <= bits_avail)
//   consume_err    one-cycle pulse for a rejected consume
//   align          drop bits up to the next byte boundary
//   flush          synchronous clear of all state
//   marker_valid   sticky marker flag, marker_code = second marker byte
//   stuff_cnt      removed stuff byte count
// ---------------------------------------------------------------------------
module jpeg_bit_window #(
    parameter int  WIN_W  = 32,
    parameter int  PEEK_W = 16,
    localparam int AW     = $clog2(WIN_W + 1),
    localparam int CW     = $clog2(PEEK_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    output logic [PEEK_W-1:0] peek_bits,
    output logic [AW-1:0]     bits_avail,
    input  logic              consume_valid,
    input  logic [CW-1:0]     consume_len,
    output logic              consume_err,
    input  logic              align,
    input  logic              flush,
    output logic              marker_valid,
    output logic [7:0]        marker_code,
    output logic [15:0]       stuff_cnt
);

    // state      | meaning
    // ST_ACCEPT  | normal intake, bytes appended as data
    // ST_FF_PEND | an 0xFF was taken; next byte decides stuff/fill/marker
    // ST_HALT    | marker seen; intake stopped until flush or reset
    typedef enum logic [1:0] {
        ST_ACCEPT  = 2'd0,
        ST_FF_PEND = 2'd1,
        ST_HALT    = 2'd2
    } state_t;

    localparam logic [AW-1:0] FILL_MAX = AW'(WIN_W - 8);
    localparam logic [AW-1:0] PEEK_MAX = AW'(PEEK_W);

    state_t           state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d;
    logic [AW-1:0]    avail_q, avail_d;
    logic             err_q, err_d;
    logic             mvalid_q, mvalid_d;
    logic [7:0]       mcode_q, mcode_d;

    logic [AW-1:0]    len_ext;
    logic             consume_ok;
    logic [WIN_W-1:0] win_c, win_a;
    logic [AW-1:0]    avail_c, avail_a;
    logic [2:0]       drop;
    logic             ready_c;
    logic             xfer;
    logic             app;
    logic [7:0]       app_byte;

    // Consume first, then align on what is left; the incoming byte is
    // appended behind the result. Bits past avail are kept at zero so the
    // append can simply OR the byte into place.
    always_comb begin
        len_ext    = AW'(consume_len);
        consume_ok = consume_valid && (len_ext != '0) &&
                     (len_ext <= PEEK_MAX) && (len_ext <= avail_q);
        win_c      = consume_ok ? (win_q << len_ext) : win_q;
        avail_c    = consume_ok ? (avail_q - len_ext) : avail_q;
        drop       = align ? avail_c[2:0] : 3'd0;
        win_a      = win_c << drop;
        avail_a    = avail_c - AW'(drop);
        // Room is judged after this cycle's consume so a full window can
        // take a byte in the same cycle bits are dropped. rst_n gating keeps
        // ready low throughout reset.
        ready_c    = rst_n && (state_q != ST_HALT) && !flush &&
                     (avail_c <= FILL_MAX);
        xfer       = byte_valid && ready_c;
    end

    always_comb begin
        state_d  = state_q;
        win_d    = win_a;
        avail_d  = avail_a;
        err_d    = consume_valid && !consume_ok;
        mvalid_d = mvalid_q;
        mcode_d  = mcode_q;
        app      = 1'b0;
        app_byte = byte_in;

        if (xfer) begin
            case (state_q)
                ST_ACCEPT: begin
                    if (byte_in == 8'hFF) begin
                        state_d = ST_FF_PEND;
                    end else begin
                        app = 1'b1;
                    end
                end
                ST_FF_PEND: begin
                    if (byte_in == 8'h00) begin
                        app      = 1'b1;
                        app_byte = 8'hFF;
                        state_d  = ST_ACCEPT;
                    end else if (byte_in != 8'hFF) begin
                        mvalid_d = 1'b1;
                        mcode_d  = byte_in;
                        state_d  = ST_HALT;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end

        if (app) begin
            win_d   = win_a | ({app_byte, {(WIN_W-8){1'b0}}} >> avail_a);
            avail_d = avail_a + AW'(8);
        end

        if (flush) begin
            state_d  = ST_ACCEPT;
            win_d    = '0;
            avail_d  = '0;
            err_d    = 1'b0;
            mvalid_d = 1'b0;
            mcode_d  = 8'h00;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_ACCEPT;
            win_q    <= '0;
            avail_q  <= '0;
            err_q    <= 1'b0;
            mvalid_q <= 1'b0;
            mcode_q  <= 8'h00;
        end else begin
            state_q  <= state_d;
            win_q    <= win_d;
            avail_q  <= avail_d;
            err_q    <= err_d;
            mvalid_q <= mvalid_d;
            mcode_q  <= mcode_d;
        end
    end

`ifdef JPEG_BITWIN_STUFF_CNT_EN
    logic [15:0] stuff_q, stuff_d;
    logic        stuff_inc;

    always_comb begin
        stuff_inc = xfer && (state_q == ST_FF_PEND) && (byte_in == 8'h00);
        stuff_d   = stuff_q;
        if (flush) begin
            stuff_d = 16'h0000;
        end else if (stuff_inc && (stuff_q != 16'hFFFF)) begin
            stuff_d = stuff_q + 16'h0001;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stuff_q <= 16'h0000;
        end else begin
            stuff_q <= stuff_d;
        end
    end

    assign stuff_cnt = stuff_q;
`else
    assign stuff_cnt = 16'h0000;
`endif

    assign byte_ready   = ready_c;
    assign peek_bits    = win_q[WIN_W-1 -: PEEK_W];
    assign bits_avail   = avail_q;
    assign consume_err  = err_q;
    assign marker_valid = mvalid_q;
    assign marker_code  = mcode_q;

endmodule

// File: tb/tb_jpeg_bit_window.sv
// ---------------------------------------------------------------------------
// tb_jpeg_bit_window
//
// Directed scenarios followed by a random phase. The reference model keeps
// the window as a queue of bits and the byte-stuffing state as a small
// integer; each step predicts byte_ready before the edge and every output
// after it.
// ---------------------------------------------------------------------------
module tb_jpeg_bit_window;

    localparam int WIN_W  = 32;
    localparam int PEEK_W = 16;

    logic              clk;
    logic              rst_n;
    logic [7:0]        byte_in;
    logic              byte_valid;
    logic              byte_ready;
    logic [PEEK_W-1:0] peek_bits;
    logic [5:0]        bits_avail;
    logic              consume_valid;
    logic [4:0]        consume_len;
    logic              consume_err;
    logic              align;
    logic              flush;
    logic              marker_valid;
    logic [7:0]        marker_code;
    logic [15:0]       stuff_cnt;

    jpeg_bit_window #(.WIN_W(WIN_W), .PEEK_W(PEEK_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .byte_in       (byte_in),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .peek_bits     (peek_bits),
        .bits_avail    (bits_avail),
        .consume_valid (consume_valid),
        .consume_len   (consume_len),
        .consume_err   (consume_err),
        .align         (align),
        .flush         (flush),
        .marker_valid  (marker_valid),
        .marker_code   (marker_code),
        .stuff_cnt     (stuff_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model: 0 = normal, 1 = after FF, 2 = halted on marker
    bit       m_q[$];
    int       m_state;
    bit       m_mv;
    bit [7:0] m_mc;
    int       m_stuff;
    bit       m_err;

`ifdef JPEG_BITWIN_STUFF_CNT_EN
    localparam bit STUFF_ON = 1'b1;
`else
    localparam bit STUFF_ON = 1'b0;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [PEEK_W-1:0] model_peek();
        logic [PEEK_W-1:0] p;
        p = '0;
        for (int i = 0; i < PEEK_W; i++) begin
            if (i < m_q.size()) p[PEEK_W-1-i] = m_q[i];
        end
        return p;
    endfunction

    function automatic int exp_stuff();
        return STUFF_ON ? m_stuff : 0;
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_state = 0;
        m_mv    = 1'b0;
        m_mc    = 8'h00;
        m_stuff = 0;
        m_err   = 1'b0;
    endtask

    task automatic push_byte(input bit [7:0] b);
        for (int i = 7; i >= 0; i--) m_q.push_back(b[i]);
    endtask

    task automatic check_outputs();
        chk("peek_bits",    peek_bits,    model_peek());
        chk("bits_avail",   bits_avail,   m_q.size());
        chk("consume_err",  consume_err,  m_err);
        chk("marker_valid", marker_valid, m_mv);
        chk("marker_code",  marker_code,  m_mc);
        chk("stuff_cnt",    stuff_cnt,    exp_stuff());
    endtask

    // Reset is asserted without waiting for a clock edge, so the outputs are
    // checked while it is still low.
    task automatic do_reset();
        byte_valid    = 1'b0;
        byte_in       = 8'h00;
        consume_valid = 1'b0;
        consume_len   = '0;
        align         = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b0;
        #1;
        chk("rst_byte_ready",   byte_ready,   0);
        chk("rst_peek_bits",    peek_bits,    0);
        chk("rst_bits_avail",   bits_avail,   0);
        chk("rst_consume_err",  consume_err,  0);
        chk("rst_marker_valid", marker_valid, 0);
        chk("rst_marker_code",  marker_code,  0);
        chk("rst_stuff_cnt",    stuff_cnt,    0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_clear();
    endtask

    task automatic step(input bit bv, input bit [7:0] b, input bit cv, input int cl,
                        input bit al, input bit fl);
        bit ok;
        bit rdy;
        int sz_after;
        byte_valid    = bv;
        byte_in       = b;
        consume_valid = cv;
        consume_len   = 5'(cl);
        align         = al;
        flush         = fl;
        #1;
        ok       = cv && (cl >= 1) && (cl <= PEEK_W) && (cl <= m_q.size());
        sz_after = m_q.size() - (ok ? cl : 0);
        rdy      = (m_state != 2) && !fl && (sz_after <= WIN_W - 8);
        chk("byte_ready", byte_ready, rdy);
        @(posedge clk);
        if (fl) begin
            model_clear();
        end else begin
            m_err = cv && !ok;
            if (ok) repeat (cl) void'(m_q.pop_front());
            if (al) repeat (m_q.size() % 8) void'(m_q.pop_front());
            if (bv && rdy) begin
                if (m_state == 0) begin
                    if (b == 8'hFF) m_state = 1;
                    else push_byte(b);
                end else if (m_state == 1) begin
                    if (b == 8'h00) begin
                        push_byte(8'hFF);
                        m_state = 0;
                        if (m_stuff < 65535) m_stuff++;
                    end else if (b != 8'hFF) begin
                        m_mv    = 1'b1;
                        m_mc    = b;
                        m_state = 2;
                    end
                end
            end
        end
        #1;
        check_outputs();
    endtask

    initial begin
        rst_n         = 1'b0;
        byte_valid    = 1'b0;
        byte_in       = 8'h00;
        consume_valid = 1'b0;
        consume_len   = '0;
        align         = 1'b0;
        flush         = 1'b0;
        model_clear();
        #2;
        do_reset();

        // stuffed FF in the middle of data
        step(1, 8'h93, 0, 0, 0, 0);
        step(1, 8'hFF, 0, 0, 0, 0);
        step(1, 8'h00, 0, 0, 0, 0);
        step(1, 8'h81, 0, 0, 0, 0);
        chk("s1_avail", bits_avail, 24);
        chk("s1_peek",  peek_bits,  16'h93FF);
        step(0, 8'h00, 1, 16, 0, 0);
        chk("s1_peek2",  peek_bits,  16'h8100);
        chk("s1_avail2", bits_avail, 8);
        chk("s1_stuff",  stuff_cnt,  STUFF_ON ? 1 : 0);

        // marker halts intake; bits stay consumable; flush recovers
        do_reset();
        step(1, 8'h12, 0, 0, 0, 0);
        step(1, 8'hFF, 0, 0, 0, 0);
        step(1, 8'hD9, 0, 0, 0, 0);
        chk("s2_mvalid", marker_valid, 1);
        chk("s2_mcode",  marker_code,  8'hD9);
        chk("s2_avail",  bits_avail,   8);
        chk("s2_ready",  byte_ready,   0);
        step(0, 8'h00, 1, 8, 0, 0);
        chk("s2_avail2", bits_avail, 0);
        chk("s2_ready2", byte_ready, 0);
        step(0, 8'h00, 0, 0, 0, 1);
        step(0, 8'h00, 0, 0, 0, 0);
        chk("s2_ready3",  byte_ready,   1);
        chk("s2_mvalid2", marker_valid, 0);

        // full window back-pressure, then consume and append in one cycle
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 8'hAA, 0, 0, 0, 0);
        chk("s3_avail", bits_avail, 32);
        chk("s3_ready", byte_ready, 0);
        step(1, 8'hAA, 1, 8, 0, 0);
        chk("s3_avail2", bits_avail, 32);

        // align and rejected consume
        do_reset();
        step(1, 8'hF0, 0, 0, 0, 0);
        step(1, 8'h0F, 0, 0, 0, 0);
        step(0, 8'h00, 1, 3, 0, 0);
        chk("s4_avail", bits_avail, 13);
        step(0, 8'h00, 0, 0, 1, 0);
        chk("s4_avail2", bits_avail, 8);
        chk("s4_peek",   peek_bits,  16'h0F00);
        step(0, 8'h00, 1, 9, 0, 0);
        chk("s4_err",    consume_err, 1);
        chk("s4_avail3", bits_avail,  8);
        step(0, 8'h00, 1, 0, 0, 0);
        chk("s4_err_zero", consume_err, 1);
        step(0, 8'h00, 0, 0, 0, 0);
        chk("s4_err_clr", consume_err, 0);

        // reset mid-operation drops the pending FF
        do_reset();
        step(1, 8'h55, 0, 0, 0, 0);
        step(1, 8'hFF, 0, 0, 0, 0);
        do_reset();
        step(1, 8'h00, 0, 0, 0, 0);
        chk("s5_avail", bits_avail, 8);
        chk("s5_peek",  peek_bits,  16'h0000);
        chk("s5_stuff", stuff_cnt,  0);

        // random phase
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            bit       bv, cv, al, fl;
            bit [7:0] b;
            int       r, cl;
            bv = ($urandom_range(0, 3) != 0);
            r  = $urandom_range(0, 9);
            if (r < 2)       b = 8'hFF;
            else if (r < 4)  b = 8'h00;
            else             b = 8'($urandom_range(0, 255));
            cv = ($urandom_range(0, 1) != 0);
            cl = $urandom_range(0, 18);
            al = ($urandom_range(0, 11) == 0);
            fl = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 499) == 0) do_reset();
            else step(bv, b, cv, cl, al, fl);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/jpeg_bit_window.md
JPEG_BIT_WINDOW -- requirements
Module: jpeg_bit_window

Interface
REQ-001 Parameter WIN_W, default 32: bit-window depth; multiple of 8, range 16..64.
REQ-002 Parameter PEEK_W, default 16: peek width; range 1..WIN_W-8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 byte_in  input  8  scan byte from the header parser pass-through.
REQ-006 byte_valid  input  1  byte_in is valid.
REQ-007 byte_ready  output  1  block accepts byte_in this cycle.
REQ-008 peek_bits  output  PEEK_W  next unconsumed bits, MSB first; bits beyond bits_avail read 0.
REQ-009 bits_avail  output  clog2(WIN_W+1)  valid bits currently in window.
REQ-010 consume_valid  input  1  request to drop consume_len bits.
REQ-011 consume_len  input  clog2(PEEK_W+1)  bits to drop, 1..PEEK_W.
REQ-012 consume_err  output  1  one-cycle pulse: rejected consume.
REQ-013 align  input  1  drop bits up to the next byte boundary (RSTn pad removal).
REQ-014 flush  input  1  synchronous clear of all state.
REQ-015 marker_valid  output  1  non-stuffed marker detected; sticky.
REQ-016 marker_code  output  8  second byte of the detected marker.
REQ-017 stuff_cnt  output  16  count of removed stuff 0x00 bytes (see Configuration).

Function
REQ-018 Window SHALL be MSB-aligned; the byte accepted when bits_avail=n SHALL occupy window bits [WIN_W-1-n -: 8].
REQ-019 A byte SHALL transfer only on byte_valid && byte_ready; its bits SHALL appear in peek_bits/bits_avail the next cycle.
REQ-020 byte_ready SHALL be 1 only when not halted, flush=0 and bits_avail <= WIN_W-8 after this cycle's consume.
REQ-021 States: ACCEPT, FF_PEND, HALT; a transfer of 0xFF in ACCEPT SHALL add no bits and go to FF_PEND.
REQ-022 In FF_PEND, transfer of 0x00 SHALL append 0xFF and return to ACCEPT; transfer of another 0xFF SHALL stay in FF_PEND (fill byte), adding nothing.
REQ-023 In FF_PEND, any other byte SHALL set marker_valid=1, marker_code=byte, enter HALT, add no bits.
REQ-024 In HALT, byte_ready SHALL be 0; window bits SHALL remain consumable; exit only via flush or reset.
REQ-025 consume_valid with 1 <= consume_len <= bits_avail SHALL shift the window left by consume_len next cycle.
REQ-026 consume_len = 0, > PEEK_W or > bits_avail SHALL be ignored and pulse consume_err for one cycle.
REQ-027 Same-cycle consume and byte transfer SHALL both apply: shift first, append at bits_avail-consume_len.
REQ-028 align SHALL drop (bits_avail mod 8) bits; when asserted with consume_valid, consume SHALL apply first, then align on the result.
REQ-029 flush SHALL override all other inputs: window, bits_avail, state, marker_valid, marker_code, stuff_cnt cleared next cycle; a byte presented that cycle SHALL NOT transfer.
REQ-030 bits_avail SHALL never exceed WIN_W nor underflow.

Reset
REQ-031 While rst_n=0: byte_ready=0, peek_bits=0, bits_avail=0, consume_err=0, marker_valid=0, marker_code=0, stuff_cnt=0, state ACCEPT.
REQ-032 Reset asserted mid-operation SHALL discard all window contents and pending FF immediately, without waiting for clk.
REQ-033 byte_ready SHALL first be 1 in the first cycle after rst_n deasserts.

Configuration
REQ-034 Macro JPEG_BITWIN_STUFF_CNT_EN defined: stuff_cnt SHALL increment on each FF_PEND 0x00 transfer, saturating at 0xFFFF.
REQ-035 Macro undefined: stuff_cnt SHALL be constant 0 and no counter register SHALL be built; all other behaviour identical.

Verification
REQ-036 WIN_W=32, PEEK_W=16: bytes 93,FF,00,81 -> bits_avail=24, peek_bits=0x93FF; consume 16 -> peek_bits=0x8100, bits_avail=8; stuff_cnt=1 (macro on) / 0 (off).
REQ-037 Bytes 12,FF,D9 -> marker_valid=1, marker_code=D9, bits_avail=8, byte_ready=0; consume 8 -> bits_avail=0, still halted; flush -> byte_ready=1, marker_valid=0.
REQ-038 byte_valid held with AA x5, no consume -> 4 transfers, bits_avail=32, byte_ready=0; consume 8 with byte_valid=1 -> 5th byte transfers in that same cycle, bits_avail=32.
REQ-039 Bytes F0,0F; consume 3 -> bits_avail=13; align -> bits_avail=8, peek_bits=0x0F00; consume_len=9 -> consume_err pulse, bits_avail unchanged.
REQ-040 Bytes 55,FF then rst_n=0 for 1 cycle, then byte 00 -> treated as data: bits_avail=8, peek_bits=0x0000, stuff_cnt=0.
